// File: rtl/mux_pipe_sel.sv
// mux_pipe_sel: registered result multiplexer with valid/ready handshake and 2-entry skid buffer.
// Optional MUX_PIPE_ADDR_ERR_EN adds addr_err, flagging entries captured with mux_address >= NUM_INPUTS.
module mux_pipe_sel #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 13,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] mux_inputs,
  input  logic [ADDR_WIDTH-1:0]          mux_address,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          mux_output,
  output logic                           out_valid,
  input  logic                           out_ready
`ifdef MUX_PIPE_ADDR_ERR_EN
  ,
  output logic                           addr_err
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] words [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] sel, skid;
  logic in_hs, out_hs, load_head, load_skid, pop_skid;
  // Every address slot is populated; out-of-range slots alias word 0 so no compare is needed.
  for (genvar g = 0; g < 2**ADDR_WIDTH; g++) begin : g_words
    if (g < NUM_INPUTS) begin : g_in
      assign words[g] = mux_inputs[g*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_oor
      assign words[g] = mux_inputs[DATA_WIDTH-1:0];
    end
  end
  assign sel = words[mux_address];
  assign out_valid = state != EMPTY;
  assign in_hs = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign load_head = in_hs && (state == EMPTY || out_hs);
  assign load_skid = in_hs && state == ONE && !out_hs;
  assign pop_skid = out_hs && state == FULL;
  always_comb begin
    state_nxt = state == EMPTY ? (in_hs ? ONE : EMPTY)
              : state == ONE ? ((in_hs && !out_hs) ? FULL : (out_hs && !in_hs) ? EMPTY : ONE)
              : (out_hs ? ONE : FULL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state <= state_nxt;
      in_ready <= state_nxt != FULL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_output <= '0;
      skid <= '0;
    end else begin
      if (load_head) mux_output <= sel;
      else if (pop_skid) mux_output <= skid;
      if (load_skid) skid <= sel;
    end
  end
`ifdef MUX_PIPE_ADDR_ERR_EN
  logic errs [2**ADDR_WIDTH];
  logic skid_err;
  for (genvar g = 0; g < 2**ADDR_WIDTH; g++) begin : g_errs
    assign errs[g] = g >= NUM_INPUTS;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
      skid_err <= 1'b0;
    end else begin
      if (load_head) addr_err <= errs[mux_address];
      else if (pop_skid) addr_err <= skid_err;
      if (load_skid) skid_err <= errs[mux_address];
    end
  end
`endif
endmodule

// File: tb/tb_mux_pipe_sel.sv
// tb_mux_pipe_sel: directed and random checks of mux_pipe_sel against a queue-based reference.
module tb_mux_pipe_sel;
  localparam int DW = 32;
  localparam int NI = 13;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [NI*DW-1:0] mux_inputs;
  logic [AW-1:0] mux_address;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] mux_output;
  logic [DW-1:0] words [NI];
  logic [DW-1:0] q [$];
  int n_checks = 0;
  int n_fails = 0;
  mux_pipe_sel #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .mux_inputs(mux_inputs), .mux_address(mux_address),
    .in_valid(in_valid), .in_ready(in_ready), .mux_output(mux_output),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  always_comb begin
    mux_inputs = '0;
    for (int k = 0; k < NI; k++) mux_inputs[k*DW +: DW] = words[k];
  end
  function automatic logic [DW-1:0] pick(input logic [AW-1:0] a);
    return int'(a) < NI ? words[a] : words[0];
  endfunction
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_model(input string tag);
    chk1({tag, ".out_valid"}, out_valid, q.size() > 0);
    chk1({tag, ".in_ready"}, in_ready, q.size() < 2);
    if (q.size() > 0) chk32({tag, ".data"}, mux_output, q[0]);
  endtask
  // Drive one cycle, advance the reference at the edge, check just after it.
  task automatic step(input string tag, input logic iv, input logic [AW-1:0] a, input logic ordy);
    logic ih, oh;
    in_valid = iv;
    mux_address = a;
    out_ready = ordy;
    @(posedge clk);
    ih = iv && q.size() < 2;
    oh = ordy && q.size() > 0;
    if (oh) void'(q.pop_front());
    if (ih) q.push_back(pick(a));
    #1 check_model(tag);
  endtask
  task automatic rand_words();
    for (int k = 0; k < NI; k++) words[k] = $urandom;
  endtask
  initial begin
    logic [DW-1:0] held;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mux_address = '0;
    rand_words();
    repeat (2) @(posedge clk);
    #1;
    chk1("reset.out_valid", out_valid, 1'b0);
    chk1("reset.in_ready", in_ready, 1'b1);
    chk32("reset.data", mux_output, '0);
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) words[k] = 32'hA000_0000 + k;
    for (int k = 0; k < NI; k++) begin
      step("stream", 1'b1, AW'(k), 1'b1);
      chk32("stream.value", mux_output, 32'hA000_0000 + k);
    end
    step("stream.drain", 1'b0, '0, 1'b1);
    step("bp.a3", 1'b1, 4'd3, 1'b0);
    step("bp.a7", 1'b1, 4'd7, 1'b0);
    chk1("bp.in_ready_low", in_ready, 1'b0);
    chk32("bp.head3", mux_output, 32'hA000_0003);
    step("bp.ignored", 1'b1, 4'd9, 1'b0);
    step("bp.pop3", 1'b0, '0, 1'b1);
    chk32("bp.out7", mux_output, 32'hA000_0007);
    chk1("bp.ready_back", in_ready, 1'b1);
    step("bp.pop7", 1'b0, '0, 1'b1);
    chk1("bp.empty", out_valid, 1'b0);
    step("stall.fill", 1'b1, 4'd5, 1'b0);
    held = mux_output;
    for (int i = 0; i < 6; i++) begin
      rand_words();
      step("stall", i[0], AW'($urandom_range(0, 15)), 1'b0);
      chk32("stall.held", mux_output, held);
    end
    step("stall.drain0", 1'b0, '0, 1'b1);
    step("stall.drain1", 1'b0, '0, 1'b1);
    words[0] = 32'h1234_5678;
    step("oor", 1'b1, 4'd15, 1'b1);
    chk32("oor.word0", mux_output, 32'h1234_5678);
    step("oor.drain", 1'b0, '0, 1'b1);
    rand_words();
    step("simul.one", 1'b1, 4'd2, 1'b0);
    step("simul.both", 1'b1, 4'd9, 1'b1);
    chk32("simul.head", mux_output, words[9]);
    chk1("simul.in_ready", in_ready, 1'b1);
    chk1("simul.out_valid", out_valid, 1'b1);
    for (int i = 0; i < 400; i++) begin
      rand_words();
      step("rand", ($urandom % 4) != 0, AW'($urandom_range(0, 15)), ($urandom % 3) != 0);
    end
    step("pre_rst.a", 1'b1, 4'd1, 1'b0);
    step("pre_rst.b", 1'b1, 4'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk1("midrst.out_valid", out_valid, 1'b0);
    chk1("midrst.in_ready", in_ready, 1'b1);
    chk32("midrst.data", mux_output, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_rst", 1'b1, 4'd5, 1'b1);
    chk32("post_rst.word5", mux_output, words[5]);
    chk1("post_rst.valid", out_valid, 1'b1);
    step("end.drain", 1'b0, '0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/mux_pipe_sel.md
Name: mux_pipe_sel

Overview:
- Parametrised successor of the ALU result multiplexer.
- Selects one of NUM_INPUTS result words by mux_address and registers the selection.
- Delivers the result through a valid/ready handshake with a 2-entry skid buffer, so ALU back-pressure never drops or duplicates a result.
- Sits between the ALU function units and the writeback/register-file stage.

Parameters:
- DATA_WIDTH, 32, width of each input word and of mux_output.
- NUM_INPUTS, 13, number of selectable inputs (2..64).
- ADDR_WIDTH, 4, width of mux_address; must satisfy 2**ADDR_WIDTH >= NUM_INPUTS.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- mux_inputs  input  NUM_INPUTS*DATA_WIDTH  flattened inputs; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- mux_address  input  ADDR_WIDTH  select; sampled only on an input handshake.
- in_valid  input  1  upstream offers mux_inputs/mux_address.
- in_ready  output  1  block accepts this cycle.
- mux_output  output  DATA_WIDTH  selected word at the head of the buffer.
- out_valid  output  1  mux_output is valid.
- out_ready  input  1  downstream consumes this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: mux_output = 0, out_valid = 0, in_ready = 1, both buffer entries invalid, state EMPTY. Assertion mid-transfer discards all held entries immediately, asynchronously.
- Selection:
  - word = mux_inputs word[mux_address] when mux_address < NUM_INPUTS.
  - Otherwise word = word 0 (out-of-range default).
  - Purely combinational ahead of the capture register.
- Handshakes:
  - Input handshake: in_valid & in_ready at a rising edge.
  - Output handshake: out_valid & out_ready at a rising edge.
- Latency: an accepted word appears on mux_output with out_valid = 1 on the cycle after acceptance when the buffer was EMPTY. Throughput is 1 word/cycle while out_ready is held high.
- State machine (count of held entries):
  - EMPTY: in_ready = 1, out_valid = 0. Input handshake -> ONE.
  - ONE: in_ready = 1, out_valid = 1.
    - Input only -> FULL; the new word goes to the skid entry.
    - Output only -> EMPTY.
    - Both -> ONE; the head is replaced by the new word.
    - Neither -> ONE, hold.
  - FULL: in_ready = 0, out_valid = 1. Output handshake -> ONE; the skid entry moves to the head. No input is accepted.
- in_ready is a registered output, derived from next state != FULL. No combinational path from out_ready to in_ready.
- While out_valid = 1 and out_ready = 0, mux_output is held stable; changes on mux_inputs or mux_address do not propagate.
- in_valid while in_ready = 0 is ignored; upstream must hold its data.
- Ordering: strictly FIFO; words leave in acceptance order.
- No arithmetic; words pass bit-exact.

Optional Feature:
- Macro MUX_PIPE_ADDR_ERR_EN.
- Defined:
  - Adds output port addr_err (1 bit, reset 0), carried in each buffer entry alongside its word.
  - addr_err = 1 with the word exactly when the captured mux_address >= NUM_INPUTS. The data is still word 0.
  - addr_err follows the head entry, with the same timing as mux_output.
- Undefined: no addr_err port and no extra storage. Out-of-range addresses silently select word 0.

Test Plan:
- Reset: rst_n = 0 mid-traffic -> immediately out_valid = 0, mux_output = 0, in_ready = 1; after release, first accepted word appears one cycle later.
- Streaming: out_ready = 1, addresses 0..12 on consecutive cycles, input k = 32'hA000_0000 + k -> outputs A0000000..A000000C, one per cycle, 1-cycle latency.
- Back-pressure:
  - out_ready = 0, send address 3 then address 7 -> in_ready drops to 0 after the second acceptance; mux_output holds input 3.
  - Raise out_ready -> input 3, then input 7, in order; nothing lost or duplicated.
- Input change under stall: hold out_ready = 0 and toggle all mux_inputs and mux_address -> mux_output unchanged.
- Out-of-range: mux_address = 15 with input 0 = 32'h1234_5678 -> output 32'h1234_5678. With MUX_PIPE_ADDR_ERR_EN defined, addr_err = 1 on that word only.
- Simultaneous: state ONE, in_valid and out_ready both 1 -> state remains ONE, the new word is on the head next cycle, in_ready stays 1.
